// File: rtl/next_line_predictor_pkg.sv
// Shared types, counter constants and index helper for the next-line predictor.
// Optional feature macro: NLP_UPD_BYPASS_EN (same-cycle write-to-lookup forwarding).
package nlp_pkg;

  // Widest tag the entry struct can carry; the table stores only TAG_W bits.
  localparam int NLP_TAG_W_MAX = 24;

  localparam logic [1:0] NLP_CNT_WEAK_T = 2'b10;
  localparam logic [1:0] NLP_CNT_MAX    = 2'b11;

  typedef struct packed {
    logic                     valid;
    logic [NLP_TAG_W_MAX-1:0] tag;
    logic [29:0]              target;  // target[31:2]; low bits read back as 0
    logic [1:0]               cnt;
  } nlp_entry_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } nlp_upd_t;

  // Table index: pc[idx_w+1:2], returned zero-extended to 32 bits.
  function automatic logic [31:0] nlp_idx(input logic [31:0] pc, input int idx_w);
    return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

endpackage

// File: rtl/next_line_predictor_if.sv
// Lookup, prediction and training bundle of the next-line predictor.
// Optional feature macro: NLP_UPD_BYPASS_EN (no effect on this interface).
interface next_line_predictor_if;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        clear;
  logic [1:0]  pred_valid;
  logic [1:0]  pred_taken;
  logic [63:0] pred_target;
  logic        if3_upd_valid;
  logic        if3_upd_taken;
  logic [31:0] if3_upd_pc;
  logic [31:0] if3_upd_target;
  logic        be_upd_valid;
  logic        be_upd_taken;
  logic [31:0] be_upd_pc;
  logic [31:0] be_upd_target;

  // Fetch/training side
  modport master (
    output lookup_valid, lookup_pc, clear,
    output if3_upd_valid, if3_upd_taken, if3_upd_pc, if3_upd_target,
    output be_upd_valid, be_upd_taken, be_upd_pc, be_upd_target,
    input  pred_valid, pred_taken, pred_target
  );

  // Predictor side
  modport slave (
    input  lookup_valid, lookup_pc, clear,
    input  if3_upd_valid, if3_upd_taken, if3_upd_pc, if3_upd_target,
    input  be_upd_valid, be_upd_taken, be_upd_pc, be_upd_target,
    output pred_valid, pred_taken, pred_target
  );
endinterface

// File: rtl/nlp_table.sv
// Predictor storage: two lookup read ports, two read-modify-write update ports,
// port arbitration (port 1 = backend beats port 0 = IF3 on equal index) and clear.
// Optional feature macro: NLP_UPD_BYPASS_EN forwards committed writes to same-cycle lookups.
module nlp_table
  import nlp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [IDX_W-1:0] rd_idx   [2],
  output nlp_entry_t       rd_entry [2],
  input  logic [IDX_W-1:0] ur_idx   [2],
  output nlp_entry_t       ur_entry [2],
  input  logic [1:0]       wr_en,
  input  logic [1:0]       wr_req,
  input  logic [IDX_W-1:0] wr_idx   [2],
  input  nlp_entry_t       wr_entry [2]
);

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         cnt_q [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [29:0]        tgt_q [ENTRIES];
  logic [1:0]         commit;

  // A write commits unless clear is up; IF3 also yields to any backend request on its index.
  assign commit[1] = !clear && wr_en[1];
  assign commit[0] = !clear && wr_en[0] && !(wr_req[1] && (wr_idx[1] == wr_idx[0]));

  // Valid bits and counters: cleared by reset, valid bits also by clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int e = 0; e < ENTRIES; e++) cnt_q[e] <= 2'b00;
    end else if (clear) begin
      valid_q <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (commit[p]) begin
          valid_q[wr_idx[p]] <= wr_entry[p].valid;
          cnt_q[wr_idx[p]]   <= wr_entry[p].cnt;
        end
      end
    end
  end

  // Tags and targets carry no reset; they are only meaningful behind a valid bit.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (commit[p]) begin
        tag_q[wr_idx[p]] <= wr_entry[p].tag[TAG_W-1:0];
        tgt_q[wr_idx[p]] <= wr_entry[p].target;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      nlp_entry_t raw;
      assign raw = '{valid:  valid_q[rd_idx[gi]],
                     tag:    NLP_TAG_W_MAX'(tag_q[rd_idx[gi]]),
                     target: tgt_q[rd_idx[gi]],
                     cnt:    cnt_q[rd_idx[gi]]};
      assign ur_entry[gi] = '{valid:  valid_q[ur_idx[gi]],
                              tag:    NLP_TAG_W_MAX'(tag_q[ur_idx[gi]]),
                              target: tgt_q[ur_idx[gi]],
                              cnt:    cnt_q[ur_idx[gi]]};
`ifdef NLP_UPD_BYPASS_EN
      nlp_entry_t fwd;
      // Lookup sees the post-write contents of its own index in the write cycle.
      always_comb begin
        fwd = raw;
        if (clear) begin
          fwd.valid = 1'b0;
        end else if (commit[1] && (wr_idx[1] == rd_idx[gi])) begin
          fwd = wr_entry[1];
        end else if (commit[0] && (wr_idx[0] == rd_idx[gi])) begin
          fwd = wr_entry[0];
        end
      end
      assign rd_entry[gi] = fwd;
`else
      assign rd_entry[gi] = raw;
`endif
    end
  endgenerate

endmodule

// File: rtl/next_line_predictor.sv
// Next-line predictor for IF0: 2-wide fetch group lookup with 1-cycle latency,
// trained from IF3 pre-decode and backend resolution.
// Optional feature macro: NLP_UPD_BYPASS_EN (same-cycle update forwarding, inside nlp_table).
module next_line_predictor
  import nlp_pkg::*;
#(
  parameter int ENTRIES = 64,  // power of two, at least 4
  parameter int TAG_W   = 8
) (
  input logic                 clk,
  input logic                 rst,
  next_line_predictor_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);

  function automatic logic [NLP_TAG_W_MAX-1:0] tag_of(input logic [31:0] pc);
    return NLP_TAG_W_MAX'(pc[IDX_W+2 +: TAG_W]);
  endfunction

  logic [31:0]      slot_pc  [2];
  logic [1:0]       slot_en;
  logic [1:0]       slot_hit;
  logic [IDX_W-1:0] rd_idx   [2];
  nlp_entry_t       rd_entry [2];

  nlp_upd_t         upd      [2];
  logic [IDX_W-1:0] upd_idx  [2];
  nlp_entry_t       upd_cur  [2];
  nlp_entry_t       upd_new  [2];
  logic [1:0]       upd_wen;
  logic [1:0]       upd_req;

  logic [1:0]       pred_valid_reg;
  logic [1:0]       pred_taken_reg;
  logic [63:0]      pred_target_reg;

  // Slot 1 exists only when slot 0 sits in the lower half of an 8-byte fetch group.
  assign slot_pc[0] = bus.lookup_pc;
  assign slot_pc[1] = bus.lookup_pc + 32'd4;
  assign slot_en    = {~bus.lookup_pc[2], 1'b1};

  // Port 0 is IF3, port 1 is the backend.
  assign upd[0] = '{valid: bus.if3_upd_valid, pc: bus.if3_upd_pc,
                    target: bus.if3_upd_target, taken: bus.if3_upd_taken};
  assign upd[1] = '{valid: bus.be_upd_valid, pc: bus.be_upd_pc,
                    target: bus.be_upd_target, taken: bus.be_upd_taken};
  assign upd_req = {upd[1].valid, upd[0].valid};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      assign rd_idx[gi]   = IDX_W'(nlp_idx(slot_pc[gi], IDX_W));
      assign slot_hit[gi] = slot_en[gi] && rd_entry[gi].valid &&
                            (rd_entry[gi].tag == tag_of(slot_pc[gi]));
    end

    for (gi = 0; gi < 2; gi++) begin : g_upd
      logic                     hit;
      logic                     wen;
      logic [NLP_TAG_W_MAX-1:0] tag;
      nlp_entry_t               nxt;
      assign tag         = tag_of(upd[gi].pc);
      assign upd_idx[gi] = IDX_W'(nlp_idx(upd[gi].pc, IDX_W));
      assign hit         = upd_cur[gi].valid && (upd_cur[gi].tag == tag);
      // Training: hit moves the counter, taken miss allocates, not-taken miss is ignored.
      always_comb begin
        nxt = upd_cur[gi];
        wen = 1'b0;
        if (upd[gi].valid) begin
          if (hit) begin
            wen = 1'b1;
            if (upd[gi].taken) begin
              nxt.cnt    = (upd_cur[gi].cnt == NLP_CNT_MAX) ? NLP_CNT_MAX : upd_cur[gi].cnt + 2'd1;
              nxt.target = upd[gi].target[31:2];
            end else begin
              nxt.cnt    = (upd_cur[gi].cnt == 2'b00) ? 2'b00 : upd_cur[gi].cnt - 2'd1;
            end
          end else if (upd[gi].taken) begin
            wen        = 1'b1;
            nxt.valid  = 1'b1;
            nxt.tag    = tag;
            nxt.target = upd[gi].target[31:2];
            nxt.cnt    = NLP_CNT_WEAK_T;
          end
        end
      end
      assign upd_new[gi] = nxt;
      assign upd_wen[gi] = wen;
    end
  endgenerate

  nlp_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .clear    (bus.clear),
    .rd_idx   (rd_idx),
    .rd_entry (rd_entry),
    .ur_idx   (upd_idx),
    .ur_entry (upd_cur),
    .wr_en    (upd_wen),
    .wr_req   (upd_req),
    .wr_idx   (upd_idx),
    .wr_entry (upd_new)
  );

  // Prediction registers; a missing slot loads zero taken/target, an idle cycle holds them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid_reg  <= 2'b00;
      pred_taken_reg  <= 2'b00;
      pred_target_reg <= 64'd0;
    end else if (bus.lookup_valid) begin
      pred_valid_reg <= slot_hit;
      for (int s = 0; s < 2; s++) begin
        pred_taken_reg[s]            <= slot_hit[s] & rd_entry[s].cnt[1];
        pred_target_reg[s*32 +: 32]  <= slot_hit[s] ? {rd_entry[s].target, 2'b00} : 32'd0;
      end
    end else begin
      pred_valid_reg <= 2'b00;
    end
  end

  assign bus.pred_valid  = pred_valid_reg;
  assign bus.pred_taken  = pred_taken_reg;
  assign bus.pred_target = pred_target_reg;

endmodule

// File: tb/tb_next_line_predictor.sv
// Self-checking bench for next_line_predictor: directed vector table, hand-written
// same-cycle / reset sequences, then randomized traffic against a behavioural model.
module tb_next_line_predictor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  next_line_predictor_if bus ();

  next_line_predictor #(.ENTRIES(64), .TAG_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic drive_idle();
    bus.lookup_valid   = 1'b0;
    bus.lookup_pc      = 32'd0;
    bus.clear          = 1'b0;
    bus.if3_upd_valid  = 1'b0;
    bus.if3_upd_taken  = 1'b0;
    bus.if3_upd_pc     = 32'd0;
    bus.if3_upd_target = 32'd0;
    bus.be_upd_valid   = 1'b0;
    bus.be_upd_taken   = 1'b0;
    bus.be_upd_pc      = 32'd0;
    bus.be_upd_target  = 32'd0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string       name;
    logic        be_v;
    logic [31:0] be_pc;
    logic [31:0] be_tgt;
    logic        be_tk;
    logic        i3_v;
    logic [31:0] i3_pc;
    logic [31:0] i3_tgt;
    logic        i3_tk;
    logic        clr;
    logic [31:0] lk_pc;
    logic [1:0]  ev;
    logic [1:0]  et;
    logic [31:0] eg0;
    logic [31:0] eg1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic be_v, logic [31:0] be_pc, logic [31:0] be_tgt,
                              logic be_tk, logic i3_v, logic [31:0] i3_pc, logic [31:0] i3_tgt,
                              logic i3_tk, logic clr, logic [31:0] lk, logic [1:0] ev,
                              logic [1:0] et, logic [31:0] g0, logic [31:0] g1);
    vec_t v;
    v.name = nm; v.be_v = be_v; v.be_pc = be_pc; v.be_tgt = be_tgt; v.be_tk = be_tk;
    v.i3_v = i3_v; v.i3_pc = i3_pc; v.i3_tgt = i3_tgt; v.i3_tk = i3_tk; v.clr = clr;
    v.lk_pc = lk; v.ev = ev; v.et = et; v.eg0 = g0; v.eg1 = g1;
    return v;
  endfunction

  // ---------------- behavioural reference model ----------------
  bit          m_valid [64];
  int          m_tag   [64];
  int          m_cnt   [64];
  logic [31:0] m_tgt   [64];

  function automatic int midx(logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic int mtag(logic [31:0] pc);
    return int'((pc >> 8) % 256);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0; m_cnt[i] = 0; m_tag[i] = 0; m_tgt[i] = 32'd0;
    end
  endfunction

  function automatic void model_train(logic [31:0] pc, logic [31:0] tgt, logic tk);
    int i = midx(pc);
    if (m_valid[i] && m_tag[i] == mtag(pc)) begin
      if (tk) begin
        m_cnt[i] = (m_cnt[i] + 1 > 3) ? 3 : m_cnt[i] + 1;
        m_tgt[i] = tgt & ~32'd3;
      end else begin
        m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
      end
    end else if (tk) begin
      m_valid[i] = 1'b1; m_tag[i] = mtag(pc); m_tgt[i] = tgt & ~32'd3; m_cnt[i] = 2;
    end
  endfunction

  function automatic void model_cycle(logic clr, logic be_v, logic [31:0] be_pc, logic [31:0] be_tgt,
                                      logic be_tk, logic i3_v, logic [31:0] i3_pc,
                                      logic [31:0] i3_tgt, logic i3_tk);
    if (clr) begin
      for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    end else begin
      if (be_v) model_train(be_pc, be_tgt, be_tk);
      if (i3_v && !(be_v && midx(be_pc) == midx(i3_pc))) model_train(i3_pc, i3_tgt, i3_tk);
    end
  endfunction

  logic [1:0]  exp_v;
  logic [1:0]  exp_t;
  logic [31:0] exp_g [2];
  logic [1:0]  known;

  function automatic void model_predict(logic lv, logic [31:0] pc);
    if (lv) begin
      for (int s = 0; s < 2; s++) begin
        logic [31:0] p = pc + 32'(4 * s);
        bit hv = (s == 0 || pc[2] == 1'b0) && m_valid[midx(p)] && m_tag[midx(p)] == mtag(p);
        exp_v[s] = hv;
        known[s] = hv;
        if (hv) begin
          exp_t[s] = (m_cnt[midx(p)] >= 2);
          exp_g[s] = m_tgt[midx(p)];
        end
      end
    end else begin
      exp_v = 2'b00;
    end
  endfunction

  // ---------------- stimulus ----------------
  function automatic logic [31:0] rpc();
    return 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 1)) << 8)
           | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    drive_idle();
    model_reset();

    // Reset: first lookup after reset misses with zero outputs.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.lookup_valid = 1'b1;
    bus.lookup_pc    = 32'h8000_0000;
    @(negedge clk);
    bus.lookup_valid = 1'b0;
    chk("reset_valid",  bus.pred_valid,  2'b00);
    chk("reset_taken",  bus.pred_taken,  2'b00);
    chk("reset_target", bus.pred_target, 64'd0);

    //              name            be_v be_pc         be_tgt        tk  i3 i3_pc         i3_tgt        tk  clr lookup        ev     et     eg0           eg1
    vecs.push_back(mk("alloc",      1, 32'h8000_0010, 32'h8000_0100, 1, 0, 32'h0,        32'h0,        0, 0, 32'h8000_0010, 2'b01, 2'b01, 32'h8000_0100, 32'h0));
    vecs.push_back(mk("nt1",        1, 32'h8000_0010, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 32'h8000_0010, 2'b01, 2'b00, 32'h8000_0100, 32'h0));
    vecs.push_back(mk("nt2",        1, 32'h8000_0010, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 32'h8000_0010, 2'b01, 2'b00, 32'h8000_0100, 32'h0));
    vecs.push_back(mk("nt3",        1, 32'h8000_0010, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 32'h8000_0010, 2'b01, 2'b00, 32'h8000_0100, 32'h0));
    vecs.push_back(mk("tk1",        1, 32'h8000_0010, 32'h8000_0100, 1, 0, 32'h0,        32'h0,        0, 0, 32'h8000_0010, 2'b01, 2'b00, 32'h8000_0100, 32'h0));
    vecs.push_back(mk("tk2",        1, 32'h8000_0010, 32'h8000_0100, 1, 0, 32'h0,        32'h0,        0, 0, 32'h8000_0010, 2'b01, 2'b01, 32'h8000_0100, 32'h0));
    vecs.push_back(mk("tk3",        1, 32'h8000_0010, 32'h8000_0100, 1, 0, 32'h0,        32'h0,        0, 0, 32'h8000_0010, 2'b01, 2'b01, 32'h8000_0100, 32'h0));
    vecs.push_back(mk("tk4",        1, 32'h8000_0010, 32'h8000_0100, 1, 0, 32'h0,        32'h0,        0, 0, 32'h8000_0010, 2'b01, 2'b01, 32'h8000_0100, 32'h0));
    vecs.push_back(mk("sat_nt",     1, 32'h8000_0010, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 32'h8000_0010, 2'b01, 2'b01, 32'h8000_0100, 32'h0));
    vecs.push_back(mk("odd_slot",   0, 32'h0,        32'h0,        0, 1, 32'h8000_0018, 32'h8000_0200, 1, 0, 32'h8000_0014, 2'b00, 2'b00, 32'h0,        32'h0));
    vecs.push_back(mk("odd_direct", 0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 32'h8000_0018, 2'b01, 2'b01, 32'h8000_0200, 32'h0));
    vecs.push_back(mk("slot1_hit",  1, 32'h8000_0014, 32'h8000_0300, 1, 0, 32'h0,        32'h0,        0, 0, 32'h8000_0010, 2'b11, 2'b11, 32'h8000_0100, 32'h8000_0300));
    vecs.push_back(mk("conflict",   1, 32'h8000_0020, 32'h8000_0B00, 1, 1, 32'h8000_0020, 32'h8000_0A00, 1, 0, 32'h8000_0020, 2'b01, 2'b01, 32'h8000_0B00, 32'h0));
    vecs.push_back(mk("dual_if3",   1, 32'h8000_0030, 32'h8000_0D00, 1, 1, 32'h8000_0028, 32'h8000_0C00, 1, 0, 32'h8000_0028, 2'b01, 2'b01, 32'h8000_0C00, 32'h0));
    vecs.push_back(mk("dual_be",    0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 32'h8000_0030, 2'b01, 2'b01, 32'h8000_0D00, 32'h0));
    vecs.push_back(mk("clear_upd",  1, 32'h8000_0040, 32'h8000_0F00, 1, 0, 32'h0,        32'h0,        0, 1, 32'h8000_0040, 2'b00, 2'b00, 32'h0,        32'h0));
    vecs.push_back(mk("cleared",    0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 32'h8000_0010, 2'b00, 2'b00, 32'h0,        32'h0));
    vecs.push_back(mk("realloc",    1, 32'h8000_0010, 32'h8000_0500, 1, 0, 32'h0,        32'h0,        0, 0, 32'h8000_0010, 2'b01, 2'b01, 32'h8000_0500, 32'h0));
    vecs.push_back(mk("alias",      0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 32'h8000_1010, 2'b00, 2'b00, 32'h0,        32'h0));

    foreach (vecs[k]) begin
      @(negedge clk);
      drive_idle();
      bus.be_upd_valid   = vecs[k].be_v;
      bus.be_upd_pc      = vecs[k].be_pc;
      bus.be_upd_target  = vecs[k].be_tgt;
      bus.be_upd_taken   = vecs[k].be_tk;
      bus.if3_upd_valid  = vecs[k].i3_v;
      bus.if3_upd_pc     = vecs[k].i3_pc;
      bus.if3_upd_target = vecs[k].i3_tgt;
      bus.if3_upd_taken  = vecs[k].i3_tk;
      bus.clear          = vecs[k].clr;
      @(negedge clk);
      drive_idle();
      bus.lookup_valid = 1'b1;
      bus.lookup_pc    = vecs[k].lk_pc;
      @(negedge clk);
      bus.lookup_valid = 1'b0;
      chk({vecs[k].name, "_valid"}, bus.pred_valid, vecs[k].ev);
      for (int s = 0; s < 2; s++) begin
        if (vecs[k].ev[s]) begin
          chk($sformatf("%s_taken%0d", vecs[k].name, s), bus.pred_taken[s], vecs[k].et[s]);
          chk($sformatf("%s_target%0d", vecs[k].name, s), bus.pred_target[s*32 +: 32],
              (s == 0) ? vecs[k].eg0 : vecs[k].eg1);
        end
      end
      // Idle cycle: valid drops, taken/target hold.
      @(negedge clk);
      chk({vecs[k].name, "_idle_valid"}, bus.pred_valid, 2'b00);
      if (vecs[k].ev[0]) begin
        chk({vecs[k].name, "_hold_taken"}, bus.pred_taken[0], vecs[k].et[0]);
        chk({vecs[k].name, "_hold_target"}, bus.pred_target[31:0], vecs[k].eg0);
      end
      $display("vec %s: lookup %h valid %b taken %b", vecs[k].name, vecs[k].lk_pc,
               bus.pred_valid, bus.pred_taken);
    end

    // Same-cycle allocate and lookup.
    @(negedge clk);
    drive_idle();
    bus.be_upd_valid = 1'b1; bus.be_upd_taken = 1'b1;
    bus.be_upd_pc = 32'h8000_0060; bus.be_upd_target = 32'h8000_0E00;
    bus.lookup_valid = 1'b1; bus.lookup_pc = 32'h8000_0060;
    @(negedge clk);
    drive_idle();
`ifdef NLP_UPD_BYPASS_EN
    chk("same_cycle_valid",  bus.pred_valid, 2'b01);
    chk("same_cycle_target", bus.pred_target[31:0], 32'h8000_0E00);
`else
    chk("same_cycle_valid",  bus.pred_valid, 2'b00);
`endif
    bus.lookup_valid = 1'b1; bus.lookup_pc = 32'h8000_0060;
    @(negedge clk);
    drive_idle();
    chk("next_cycle_valid",  bus.pred_valid, 2'b01);
    chk("next_cycle_target", bus.pred_target[31:0], 32'h8000_0E00);
    $display("seq same_cycle: valid %b target %h", bus.pred_valid, bus.pred_target[31:0]);

    // Clear together with a lookup of a present entry.
    bus.clear = 1'b1; bus.lookup_valid = 1'b1; bus.lookup_pc = 32'h8000_0060;
    @(negedge clk);
    drive_idle();
`ifdef NLP_UPD_BYPASS_EN
    chk("clear_same_cycle", bus.pred_valid, 2'b00);
`else
    chk("clear_same_cycle", bus.pred_valid, 2'b01);
`endif
    bus.lookup_valid = 1'b1; bus.lookup_pc = 32'h8000_0060;
    @(negedge clk);
    drive_idle();
    chk("after_clear", bus.pred_valid, 2'b00);
    $display("seq clear: valid %b", bus.pred_valid);

    // Mid-operation reset.
    bus.be_upd_valid = 1'b1; bus.be_upd_taken = 1'b1;
    bus.be_upd_pc = 32'h8000_0070; bus.be_upd_target = 32'h8000_0700;
    @(negedge clk);
    drive_idle();
    bus.lookup_valid = 1'b1; bus.lookup_pc = 32'h8000_0070;
    @(negedge clk);
    drive_idle();
    chk("pre_rst_valid", bus.pred_valid, 2'b01);
    chk("pre_rst_target", bus.pred_target[31:0], 32'h8000_0700);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid",  bus.pred_valid,  2'b00);
    chk("async_rst_taken",  bus.pred_taken,  2'b00);
    chk("async_rst_target", bus.pred_target, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.lookup_valid = 1'b1; bus.lookup_pc = 32'h8000_0070;
    @(negedge clk);
    drive_idle();
    chk("post_rst_lookup", bus.pred_valid, 2'b00);
    $display("seq reset: valid %b target %h", bus.pred_valid, bus.pred_target);

    // Randomized traffic against the model (table is empty after the reset above).
    model_reset();
    exp_v = 2'b00; exp_t = 2'b00; exp_g[0] = 32'd0; exp_g[1] = 32'd0; known = 2'b00;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (c > 0) begin
        chk($sformatf("rand%0d_valid", c), bus.pred_valid, exp_v);
        for (int s = 0; s < 2; s++) begin
          if (known[s]) begin
            chk($sformatf("rand%0d_taken%0d", c, s), bus.pred_taken[s], exp_t[s]);
            chk($sformatf("rand%0d_target%0d", c, s), bus.pred_target[s*32 +: 32], exp_g[s]);
          end
        end
      end
      bus.lookup_valid   = ($urandom_range(0, 3) != 0);
      bus.lookup_pc      = rpc();
      bus.clear          = ($urandom_range(0, 31) == 0);
      bus.be_upd_valid   = 1'($urandom_range(0, 1));
      bus.be_upd_taken   = ($urandom_range(0, 2) != 0);
      bus.be_upd_pc      = rpc();
      bus.be_upd_target  = $urandom;
      bus.if3_upd_valid  = 1'($urandom_range(0, 1));
      bus.if3_upd_taken  = ($urandom_range(0, 2) != 0);
      bus.if3_upd_pc     = rpc();
      bus.if3_upd_target = $urandom;
`ifdef NLP_UPD_BYPASS_EN
      model_cycle(bus.clear, bus.be_upd_valid, bus.be_upd_pc, bus.be_upd_target, bus.be_upd_taken,
                  bus.if3_upd_valid, bus.if3_upd_pc, bus.if3_upd_target, bus.if3_upd_taken);
      model_predict(bus.lookup_valid, bus.lookup_pc);
`else
      model_predict(bus.lookup_valid, bus.lookup_pc);
      model_cycle(bus.clear, bus.be_upd_valid, bus.be_upd_pc, bus.be_upd_target, bus.be_upd_taken,
                  bus.if3_upd_valid, bus.if3_upd_pc, bus.if3_upd_target, bus.if3_upd_taken);
`endif
      if (c % 100 == 0) $display("rand cycle %0d: lookup %h valid_exp %b", c, bus.lookup_pc, exp_v);
    end
    @(negedge clk);
    drive_idle();
    chk("rand_last_valid", bus.pred_valid, exp_v);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
